// File: rtl/sd_crc_pkg.sv
// Shared constants and state encoding for the SD data-block CRC16 sequencer.
package sd_crc_pkg;

   localparam int unsigned CRC_W          = 16;
   localparam int unsigned SD_BLOCK_BYTES = 512;
   localparam int unsigned BIT_W          = 4;
   localparam logic [CRC_W-1:0] CRC_POLY  = 16'h1021;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD   = 3'd2,
      S_SHIFT  = 3'd3,
      S_LATCH  = 3'd4,
      S_CRCOUT = 3'd5,
      S_DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/serial_CRC16.sv
// Bit-serial CRC16-CCITT LFSR (x^16+x^12+x^5+1), MSB-first, with synchronous clear.
module serial_CRC16
   import sd_crc_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENA,
   input  logic             BITVAL,
   output logic [CRC_W-1:0] CRC
);

   logic fb_c;

   assign fb_c = BITVAL ^ CRC[CRC_W-1];

   // No power-on reset: the owner clears the register before every use.
   always_ff @(posedge CLK) begin
      if (RST) begin
         CRC <= '0;
      end else if (ENA) begin
         CRC <= {CRC[CRC_W-2:0], 1'b0} ^ (fb_c ? CRC_POLY : '0);
      end
   end

endmodule

// File: rtl/sd_crc16_block_seq.sv
// Sequences the serial CRC16 over one SD data block: GEN appends the CRC, CHK tests the residue.
module sd_crc16_block_seq
   import sd_crc_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES
)(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             MODE,
   input  logic             ABORT,
   input  logic [7:0]       DIN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic             SER_BIT,
   output logic             SER_VALID,
   output logic             BUSY,
   output logic             DONE,
   output logic [CRC_W-1:0] CRC_OUT,
   output logic             CRC_OK
);

   localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 3);

   state_t            state, state_nxt;
   logic [7:0]        sreg, sreg_nxt;
   logic [CRC_W-1:0]  crc_sreg, crc_sreg_nxt;
   logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic              mode_q, mode_nxt;
   logic [CRC_W-1:0]  crc_out_nxt;
   logic              crc_ok_nxt;
   logic              ser_bit_nxt;
   logic [CNT_W-1:0]  total_c;
   logic [CRC_W-1:0]  crc_lfsr;
   logic              lfsr_clr_c;
   logic              lfsr_ena_c;

   assign lfsr_clr_c = (state == S_CLEAR);
   assign lfsr_ena_c = (state == S_SHIFT);
   assign total_c    = mode_q ? CNT_W'(BLOCK_BYTES + 2) : CNT_W'(BLOCK_BYTES);

   serial_CRC16 u_lfsr (
      .CLK    (CLK),
      .RST    (lfsr_clr_c),
      .ENA    (lfsr_ena_c),
      .BITVAL (sreg[7]),
      .CRC    (crc_lfsr)
   );

   // State, datapath and registered outputs; outputs are decoded from next-state values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         sreg      <= '0;
         crc_sreg  <= '0;
         byte_cnt  <= '0;
         bit_cnt   <= '0;
         mode_q    <= 1'b0;
         CRC_OUT   <= '0;
         CRC_OK    <= 1'b0;
         DIN_READY <= 1'b0;
         SER_BIT   <= 1'b0;
         SER_VALID <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         crc_sreg  <= crc_sreg_nxt;
         byte_cnt  <= byte_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         mode_q    <= mode_nxt;
         CRC_OUT   <= crc_out_nxt;
         CRC_OK    <= crc_ok_nxt;
         DIN_READY <= (state_nxt == S_LOAD);
         SER_BIT   <= ser_bit_nxt;
         SER_VALID <= (state_nxt == S_SHIFT) || (state_nxt == S_CRCOUT);
         BUSY      <= (state_nxt != S_IDLE);
         DONE      <= (state_nxt == S_DONE);
      end
   end

   // Next-state and datapath updates; an abort suppresses every side effect.
   always_comb begin
      state_nxt    = state;
      sreg_nxt     = sreg;
      crc_sreg_nxt = crc_sreg;
      byte_cnt_nxt = byte_cnt;
      bit_cnt_nxt  = bit_cnt;
      mode_nxt     = mode_q;
      crc_out_nxt  = CRC_OUT;
      crc_ok_nxt   = CRC_OK;

      if (ABORT) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  state_nxt = S_CLEAR;
                  mode_nxt  = MODE;
               end
            end
            S_CLEAR: begin
               byte_cnt_nxt = '0;
               crc_ok_nxt   = 1'b0;
               crc_out_nxt  = '0;
               state_nxt    = S_LOAD;
            end
            S_LOAD: begin
               if (DIN_VALID) begin
                  sreg_nxt    = DIN;
                  bit_cnt_nxt = '0;
                  state_nxt   = S_SHIFT;
               end
            end
            S_SHIFT: begin
               sreg_nxt    = {sreg[6:0], 1'b0};
               bit_cnt_nxt = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_W'(7)) begin
                  byte_cnt_nxt = byte_cnt + CNT_W'(1);
                  state_nxt    = (byte_cnt_nxt == total_c) ? S_LATCH : S_LOAD;
               end
            end
            S_LATCH: begin
               crc_out_nxt  = crc_lfsr;
               crc_sreg_nxt = crc_lfsr;
               crc_ok_nxt   = mode_q ? (crc_lfsr == '0) : 1'b1;
               bit_cnt_nxt  = '0;
               state_nxt    = mode_q ? S_DONE : S_CRCOUT;
            end
            S_CRCOUT: begin
               crc_sreg_nxt = {crc_sreg[CRC_W-2:0], 1'b0};
               bit_cnt_nxt  = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_W'(CRC_W - 1)) begin
                  state_nxt = S_DONE;
               end
            end
            S_DONE: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Serial output follows the register that will be shifting next cycle.
   always_comb begin
      ser_bit_nxt = 1'b0;
      if (state_nxt == S_SHIFT) begin
         ser_bit_nxt = sreg_nxt[7];
      end else if (state_nxt == S_CRCOUT) begin
         ser_bit_nxt = crc_sreg_nxt[CRC_W-1];
      end
   end

endmodule

// File: tb/tb_sd_crc16_block_seq.sv
// Directed bench for sd_crc16_block_seq: 9-byte and 512-byte instances on a shared clock.
module tb_sd_crc16_block_seq;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        START9 = 1'b0, START512 = 1'b0;
   logic        MODE = 1'b0, ABORT = 1'b0;
   logic [7:0]  DIN = 8'h00;
   logic        DIN_VALID = 1'b0;

   logic        rdy9, sbit9, sval9, busy9, done9, ok9;
   logic [15:0] crc9;
   logic        rdy512, sbit512, sval512, busy512, done512, ok512;
   logic [15:0] crc512;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  blk [0:511];

   int          r_done, r_nser, r_err, r_hs, r_ovl;
   logic [1:0]  r_pre;
   logic [2:0]  r_post;
   logic [21:0] r_snap;

   always #5 CLK = ~CLK;

   sd_crc16_block_seq #(.BLOCK_BYTES(9)) dut9 (
      .CLK(CLK), .RST_N(RST_N), .START(START9), .MODE(MODE), .ABORT(ABORT),
      .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy9), .SER_BIT(sbit9),
      .SER_VALID(sval9), .BUSY(busy9), .DONE(done9), .CRC_OUT(crc9), .CRC_OK(ok9)
   );

   sd_crc16_block_seq #(.BLOCK_BYTES(512)) dut512 (
      .CLK(CLK), .RST_N(RST_N), .START(START512), .MODE(MODE), .ABORT(ABORT),
      .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy512), .SER_BIT(sbit512),
      .SER_VALID(sval512), .BUSY(busy512), .DONE(done512), .CRC_OUT(crc512), .CRC_OK(ok512)
   );

   task automatic load_123456789();
      logic [71:0] s;
      s = "123456789";
      for (int i = 0; i < 9; i++) blk[i] = s[71-8*i -: 8];
      blk[9]  = 8'h31;
      blk[10] = 8'hC3;
   endtask

   // Drives one block (START in cycle 0) and records what the DUT put out; makes no judgement.
   task automatic run_block(input bit sel, input logic mode, input int nbytes, input bit gaps,
                            input logic [15:0] exp_crc, input int limit, input int abort_at,
                            input int rst_at, input int restart_at);
      int idx, k, j;
      logic rdy, sv, sb, dn, e;
      r_done = -1; r_nser = 0; r_err = 0; r_hs = 0; r_ovl = 0;
      r_pre = 2'b00; r_post = 3'b111; r_snap = '1;
      idx = 0; k = 0;
      @(negedge CLK);
      MODE = mode;
      DIN_VALID = 1'b0;
      if (sel) START512 = 1'b1; else START9 = 1'b1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge CLK);
         START9 = 1'b0; START512 = 1'b0; ABORT = 1'b0;
         rdy = sel ? rdy512 : rdy9;
         sv  = sel ? sval512 : sval9;
         sb  = sel ? sbit512 : sbit9;
         dn  = sel ? done512 : done9;
         if (c == restart_at) begin
            if (sel) START512 = 1'b1; else START9 = 1'b1;
         end
         if (dn) begin
            r_done = c;
            break;
         end
         if (rdy && sv) r_ovl++;
         if (sv) begin
            if (k < nbytes * 8) begin
               e = blk[k / 8][7 - (k % 8)];
               if (sb !== e) r_err++;
            end else if (k < nbytes * 8 + 16) begin
               j = 15 - (k - nbytes * 8);
               e = exp_crc[j];
               if (sb !== e) r_err++;
            end else begin
               r_err++;
            end
            k++;
            r_nser++;
         end
         if (c == abort_at) begin
            ABORT = 1'b1;
            r_pre = {sv, rdy};
         end
         if (c == abort_at + 1) r_post = {busy9 | busy512, sv, rdy};
         if (c == rst_at) begin
            r_pre = {sv, rdy};
            #2 RST_N = 1'b0;
            #1 r_snap = {busy9, done9, sval9, sbit9, rdy9, ok9, crc9};
            break;
         end
         DIN_VALID = (idx < nbytes) && (!gaps || ($urandom_range(0, 2) != 0));
         DIN = blk[(idx < nbytes) ? idx : 0];
         if (rdy && DIN_VALID) begin
            idx++;
            r_hs++;
         end
      end
      DIN_VALID = 1'b0;
   endtask

   task automatic test_reset();
      #1 RST_N = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      total++;
      if ({rdy9, sbit9, sval9, busy9, done9, ok9, crc9} !== 22'h0) begin
         bad++;
         $display("FAIL reset_dut9: got %h want 0", {rdy9, sbit9, sval9, busy9, done9, ok9, crc9});
      end
      total++;
      if ({rdy512, sbit512, sval512, busy512, done512, ok512, crc512} !== 22'h0) begin
         bad++;
         $display("FAIL reset_dut512: got %h want 0",
                  {rdy512, sbit512, sval512, busy512, done512, ok512, crc512});
      end
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_gen();
      load_123456789();
      run_block(1'b0, 1'b0, 9, 1'b0, 16'h31C3, 200, -1, -1, -1);
      total++;
      if (r_done !== 100) begin bad++; $display("FAIL gen_done_cycle: got %0d want 100", r_done); end
      total++;
      if (crc9 !== 16'h31C3) begin bad++; $display("FAIL gen_crc: got %h want 31c3", crc9); end
      total++;
      if (ok9 !== 1'b1) begin bad++; $display("FAIL gen_ok: got %b want 1", ok9); end
      total++;
      if (r_nser !== 88 || r_err !== 0) begin
         bad++; $display("FAIL gen_serial: bits=%0d errs=%0d want 88/0", r_nser, r_err);
      end
      total++;
      if ({busy9, rdy9, sval9} !== 3'b100) begin
         bad++; $display("FAIL gen_done_flags: busy/rdy/sv=%b want 100", {busy9, rdy9, sval9});
      end
      @(negedge CLK);
      total++;
      if ({done9, busy9} !== 2'b00) begin
         bad++; $display("FAIL gen_done_pulse: done/busy=%b want 00", {done9, busy9});
      end
      total++;
      if (crc9 !== 16'h31C3) begin bad++; $display("FAIL gen_crc_hold: got %h want 31c3", crc9); end
   endtask

   task automatic test_chk();
      load_123456789();
      run_block(1'b0, 1'b1, 11, 1'b0, 16'h0000, 200, -1, -1, -1);
      total++;
      if (r_done !== 102) begin bad++; $display("FAIL chk_done_cycle: got %0d want 102", r_done); end
      total++;
      if (crc9 !== 16'h0000 || ok9 !== 1'b1) begin
         bad++; $display("FAIL chk_good: crc=%h ok=%b want 0000/1", crc9, ok9);
      end
      total++;
      if (r_nser !== 88 || r_err !== 0) begin
         bad++; $display("FAIL chk_serial: bits=%0d errs=%0d want 88/0", r_nser, r_err);
      end
      blk[3] = blk[3] ^ 8'h01;
      run_block(1'b0, 1'b1, 11, 1'b0, 16'h0000, 200, -1, -1, -1);
      total++;
      if (ok9 !== 1'b0 || r_done !== 102) begin
         bad++; $display("FAIL chk_bad: ok=%b done=%0d want 0/102", ok9, r_done);
      end
      total++;
      if (crc9 === 16'h0000) begin bad++; $display("FAIL chk_bad_residue: got %h want nonzero", crc9); end
      load_123456789();
   endtask

   task automatic test_gen512();
      for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
      run_block(1'b1, 1'b0, 512, 1'b0, 16'h7FA1, 5000, -1, -1, -1);
      total++;
      if (crc512 !== 16'h7FA1) begin bad++; $display("FAIL gen512_ff_crc: got %h want 7fa1", crc512); end
      total++;
      if (r_done !== 4627 || r_err !== 0) begin
         bad++; $display("FAIL gen512_ff_seq: done=%0d errs=%0d want 4627/0", r_done, r_err);
      end
      for (int i = 0; i < 512; i++) blk[i] = 8'h00;
      run_block(1'b1, 1'b0, 512, 1'b0, 16'h0000, 5000, -1, -1, -1);
      total++;
      if (crc512 !== 16'h0000 || ok512 !== 1'b1) begin
         bad++; $display("FAIL gen512_zero_crc: crc=%h ok=%b want 0000/1", crc512, ok512);
      end
      total++;
      if (r_nser !== 4112 || r_err !== 0) begin
         bad++; $display("FAIL gen512_zero_bits: bits=%0d errs=%0d want 4112/0", r_nser, r_err);
      end
      load_123456789();
   endtask

   task automatic test_backpressure();
      load_123456789();
      run_block(1'b0, 1'b0, 9, 1'b1, 16'h31C3, 600, -1, -1, -1);
      total++;
      if (crc9 !== 16'h31C3 || r_done < 100) begin
         bad++; $display("FAIL bp_crc: crc=%h done=%0d want 31c3/>=100", crc9, r_done);
      end
      total++;
      if (r_ovl !== 0 || r_err !== 0 || r_hs !== 9) begin
         bad++; $display("FAIL bp_stream: overlap=%0d errs=%0d hs=%0d want 0/0/9", r_ovl, r_err, r_hs);
      end
   endtask

   task automatic test_abort();
      load_123456789();
      run_block(1'b0, 1'b0, 9, 1'b0, 16'h31C3, 70, 51, -1, -1);
      total++;
      if (r_pre !== 2'b10) begin bad++; $display("FAIL abort_pre: sv/rdy=%b want 10", r_pre); end
      total++;
      if (r_post !== 3'b000) begin bad++; $display("FAIL abort_post: busy/sv/rdy=%b want 000", r_post); end
      total++;
      if (r_done !== -1) begin bad++; $display("FAIL abort_no_done: got %0d want -1", r_done); end
      @(negedge CLK);
      START9 = 1'b1; ABORT = 1'b1;
      @(negedge CLK);
      START9 = 1'b0; ABORT = 1'b0;
      total++;
      if (busy9 !== 1'b0) begin bad++; $display("FAIL abort_start_same: busy=%b want 0", busy9); end
      run_block(1'b0, 1'b0, 9, 1'b0, 16'h31C3, 200, -1, -1, -1);
      total++;
      if (crc9 !== 16'h31C3 || r_done !== 100) begin
         bad++; $display("FAIL abort_rerun: crc=%h done=%0d want 31c3/100", crc9, r_done);
      end
   endtask

   task automatic test_reset_mid();
      load_123456789();
      run_block(1'b0, 1'b0, 9, 1'b0, 16'h31C3, 200, -1, 90, -1);
      total++;
      if (r_pre !== 2'b10) begin bad++; $display("FAIL rst_mid_pre: sv/rdy=%b want 10", r_pre); end
      total++;
      if (r_snap !== 22'h0) begin bad++; $display("FAIL rst_mid_outputs: got %h want 0", r_snap); end
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_busy_start();
      load_123456789();
      run_block(1'b0, 1'b0, 9, 1'b0, 16'h31C3, 200, -1, -1, 20);
      total++;
      if (r_done !== 100 || r_hs !== 9) begin
         bad++; $display("FAIL busy_start_ignored: done=%0d hs=%0d want 100/9", r_done, r_hs);
      end
      total++;
      if (crc9 !== 16'h31C3 || r_err !== 0) begin
         bad++; $display("FAIL busy_start_crc: crc=%h errs=%0d want 31c3/0", crc9, r_err);
      end
   endtask

   initial begin
      test_reset();
      test_gen();
      test_chk();
      test_gen512();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_busy_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
